// File: rtl/text_grid_pkg.sv
// Shared types and cell-arithmetic helpers for the text grid controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package text_grid_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [7:0] BS_CODE_DEFAULT = 8'h08;

  // Row/column pair wide enough for any legal field width; callers truncate.
  typedef struct packed {
    logic [15:0] row;
    logic [15:0] col;
  } cell_t;

  function automatic logic cell_in_range(input int row, input int col,
                                         input int rows, input int cols);
    return (row < rows) && (col < cols);
  endfunction

  // Cell after {row,col} in raster order, wrapping from the last cell to 0.
  function automatic cell_t next_cell(input int row, input int col,
                                      input int rows, input int cols);
    cell_t c;
    if (col >= cols - 1) begin
      c.col = 16'd0;
      c.row = (row >= rows - 1) ? 16'd0 : 16'(row + 1);
    end else begin
      c.row = 16'(row);
      c.col = 16'(col + 1);
    end
    return c;
  endfunction

  // Cell before {row,col} in raster order, wrapping from 0 to the last cell.
  function automatic cell_t prev_cell(input int row, input int col,
                                      input int rows, input int cols);
    cell_t c;
    if (col == 0) begin
      c.col = 16'(cols - 1);
      c.row = (row == 0) ? 16'(rows - 1) : 16'(row - 1);
    end else begin
      c.row = 16'(row);
      c.col = 16'(col - 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/text_occupancy_map.sv
// Per-cell occupancy bitmap: one bit per visible cell, single write port, one lookup port.
// Latency: writes land on the clock edge; lookup is combinational from the stored bits.
// Backpressure: none; every write presented is applied (clear_all wins over a bit write).
module text_occupancy_map
  import text_grid_pkg::*;
#(
  parameter int ROW_W = 4,
  parameter int COL_W = 5,
  parameter int ROWS  = 15,
  parameter int COLS  = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear_all,
  input  logic             i_wr,
  input  logic             i_wr_val,
  input  logic [ROW_W-1:0] i_wr_row,
  input  logic [COL_W-1:0] i_wr_col,
  input  logic [ROW_W-1:0] i_lk_row,
  input  logic [COL_W-1:0] i_lk_col,
  output logic             o_lk_bit
);

  localparam int NCELL = ROWS * COLS;
  localparam int IDX_W = (NCELL > 1) ? $clog2(NCELL) : 1;

  logic [NCELL-1:0] r_bits;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_lk_idx;
  logic             w_wr_ok;
  logic             w_lk_ok;

  // Flatten {row,col} to a raster index; only used when the cell is in range.
  assign w_wr_idx = IDX_W'(i_wr_row) * IDX_W'(COLS) + IDX_W'(i_wr_col);
  assign w_lk_idx = IDX_W'(i_lk_row) * IDX_W'(COLS) + IDX_W'(i_lk_col);
  assign w_wr_ok  = cell_in_range(int'(i_wr_row), int'(i_wr_col), ROWS, COLS);
  assign w_lk_ok  = cell_in_range(int'(i_lk_row), int'(i_lk_col), ROWS, COLS);

  // Cells outside the visible grid always read as empty.
  assign o_lk_bit = w_lk_ok ? r_bits[w_lk_idx] : 1'b0;

  // Bitmap storage: bulk clear has priority over a single-bit update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bits <= '0;
    end else if (i_clear_all) begin
      r_bits <= '0;
    end else if (i_wr && w_wr_ok) begin
      r_bits[w_wr_idx] <= i_wr_val;
    end
  end

endmodule

// File: rtl/text_grid_ctrl.sv
// Text RAM port owner: arbitrates VGA read, clear sweep, erase, direct write and cursor keys.
// Latency: RAM write and occupancy update on the grant edge; display bit follows one cycle later.
// Backpressure: fixed priority; losing write/key requests see ready=0 and must hold their inputs.
module text_grid_ctrl
  import text_grid_pkg::*;
#(
  parameter int              COL_W   = 5,
  parameter int              ROW_W   = 4,
  parameter int              COLS    = 20,
  parameter int              ROWS    = 15,
  parameter int              DATA_W  = 8,
  parameter logic [DATA_W-1:0] BS_CODE = DATA_W'(BS_CODE_DEFAULT),
  localparam int             ADDR_W  = ROW_W + COL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic [ADDR_W-1:0] vga_block,
  input  logic              erase_valid,
  input  logic [ADDR_W-1:0] erase_addr,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              key_valid,
  input  logic [DATA_W-1:0] key_data,
  output logic              key_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              enable_word_display,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic              busy
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_sweep;
  logic [ADDR_W-1:0] w_sweep_nxt;
  logic [ADDR_W-1:0] r_cursor;
  logic [ADDR_W-1:0] w_cursor_nxt;

  cell_t             w_next_c;
  cell_t             w_prev_c;
  logic [ADDR_W-1:0] w_next_addr;
  logic [ADDR_W-1:0] w_prev_addr;
  logic              w_erase_ok;
  logic              w_wr_ok;

  logic              w_map_clr_all;
  logic              w_map_wr;
  logic              w_map_val;
  logic [ADDR_W-1:0] w_map_addr;

  // Cursor neighbours and request range checks, all in {row,col} terms.
  assign w_next_c    = next_cell(int'(r_cursor[ADDR_W-1:COL_W]), int'(r_cursor[COL_W-1:0]), ROWS, COLS);
  assign w_prev_c    = prev_cell(int'(r_cursor[ADDR_W-1:COL_W]), int'(r_cursor[COL_W-1:0]), ROWS, COLS);
  assign w_next_addr = {ROW_W'(w_next_c.row), COL_W'(w_next_c.col)};
  assign w_prev_addr = {ROW_W'(w_prev_c.row), COL_W'(w_prev_c.col)};
  assign w_erase_ok  = cell_in_range(int'(erase_addr[ADDR_W-1:COL_W]), int'(erase_addr[COL_W-1:0]), ROWS, COLS);
  assign w_wr_ok     = cell_in_range(int'(wr_addr[ADDR_W-1:COL_W]), int'(wr_addr[COL_W-1:0]), ROWS, COLS);

  assign busy        = (r_state == ST_CLEAR);
  assign cursor_addr = r_cursor;

  // State, sweep pointer and cursor registers; reset lands in a fresh clear sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_CLEAR;
      r_sweep  <= '1;
      r_cursor <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sweep  <= w_sweep_nxt;
      r_cursor <= w_cursor_nxt;
    end
  end

  // Next state and port arbitration: read > clear sweep > erase > direct write > key.
  // The clear_req cycle itself writes nothing so no request can race the bitmap wipe.
  always_comb begin
    w_state_nxt   = r_state;
    w_sweep_nxt   = r_sweep;
    w_cursor_nxt  = r_cursor;
    ram_we        = 1'b0;
    ram_addr      = read_addr;
    ram_wdata     = '0;
    wr_ready      = 1'b0;
    key_ready     = 1'b0;
    w_map_clr_all = 1'b0;
    w_map_wr      = 1'b0;
    w_map_val     = 1'b0;
    w_map_addr    = '0;

    if (rst) begin
      // Port is quiet while reset is held.
    end else if (clear_req) begin
      w_state_nxt   = ST_CLEAR;
      w_sweep_nxt   = '1;
      w_cursor_nxt  = '0;
      w_map_clr_all = 1'b1;
    end else if (read_enable) begin
      // VGA owns the port; the sweep pointer holds.
    end else if (r_state == ST_CLEAR) begin
      ram_we   = 1'b1;
      ram_addr = r_sweep;
      if (r_sweep == '0) begin
        w_state_nxt = ST_IDLE;
      end else begin
        w_sweep_nxt = r_sweep - ADDR_W'(1);
      end
    end else if (erase_valid) begin
      ram_addr = erase_addr;
      if (w_erase_ok) begin
        ram_we     = 1'b1;
        w_map_wr   = 1'b1;
        w_map_val  = 1'b0;
        w_map_addr = erase_addr;
      end
    end else if (wr_valid) begin
      wr_ready  = 1'b1;
      ram_addr  = wr_addr;
      ram_wdata = wr_data;
      if (w_wr_ok) begin
        ram_we     = 1'b1;
        w_map_wr   = 1'b1;
        w_map_val  = 1'b1;
        w_map_addr = wr_addr;
      end
    end else if (key_valid) begin
      key_ready = 1'b1;
      ram_we    = 1'b1;
      w_map_wr  = 1'b1;
      if (key_data == BS_CODE) begin
        ram_addr     = w_prev_addr;
        w_map_val    = 1'b0;
        w_map_addr   = w_prev_addr;
        w_cursor_nxt = w_prev_addr;
      end else begin
        ram_addr     = r_cursor;
        ram_wdata    = key_data;
        w_map_val    = 1'b1;
        w_map_addr   = r_cursor;
        w_cursor_nxt = w_next_addr;
      end
    end
  end

  text_occupancy_map #(
    .ROW_W (ROW_W),
    .COL_W (COL_W),
    .ROWS  (ROWS),
    .COLS  (COLS)
  ) u_map (
    .clk         (clk),
    .rst         (rst),
    .i_clear_all (w_map_clr_all),
    .i_wr        (w_map_wr),
    .i_wr_val    (w_map_val),
    .i_wr_row    (w_map_addr[ADDR_W-1:COL_W]),
    .i_wr_col    (w_map_addr[COL_W-1:0]),
    .i_lk_row    (vga_block[ADDR_W-1:COL_W]),
    .i_lk_col    (vga_block[COL_W-1:0]),
    .o_lk_bit    (enable_word_display)
  );

endmodule
